// File: rtl/rf_pkg.sv
// Shared definitions for the register-file read stage: operand-select encodings,
// the x0 index and the default control-bundle width.
package rf_pkg;

    localparam int unsigned CTRLW_DEF = 40;
    localparam int unsigned X0_IDX    = 0;

    // Operand A: encoding 3 is unused by Decode and also selects zero
    typedef enum logic [1:0] {
        SRCA_RS1  = 2'd0,
        SRCA_PC   = 2'd1,
        SRCA_ZERO = 2'd2
    } srca_sel_e;

    typedef enum logic [1:0] {
        SRCB_RS2  = 2'd0,
        SRCB_IMM  = 2'd1,
        SRCB_ONE  = 2'd2,
        SRCB_ZERO = 2'd3
    } srcb_sel_e;

endpackage

// File: rtl/rf_read_stage_if.sv
// Decode -> RF stage -> Execute signal bundle, including the writeback port and flush.
// slave: the stage itself; master: the surrounding pipeline.
interface rf_read_stage_if #(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int CTRLW = rf_pkg::CTRLW_DEF
);
    localparam int AW = $clog2(NREG);

    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [AW-1:0]    in_rs1;
    logic [AW-1:0]    in_rs2;
    logic [AW-1:0]    in_rd;
    logic [WIDTH-1:0] in_pc;
    logic [WIDTH-1:0] in_imm;
    logic [1:0]       in_srca_sel;
    logic [1:0]       in_srcb_sel;
    logic [CTRLW-1:0] in_ctrl;

    logic             wb_en;
    logic [AW-1:0]    wb_addr;
    logic [WIDTH-1:0] wb_data;

    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    out_rd;
    logic [WIDTH-1:0] out_alua;
    logic [WIDTH-1:0] out_alub;
    logic [WIDTH-1:0] out_reg2data;
    logic [WIDTH-1:0] out_pc;
    logic [CTRLW-1:0] out_ctrl;

    modport slave (
        input  flush, in_valid, in_rs1, in_rs2, in_rd, in_pc, in_imm,
               in_srca_sel, in_srcb_sel, in_ctrl,
               wb_en, wb_addr, wb_data, out_ready,
        output in_ready, out_valid, out_rd, out_alua, out_alub,
               out_reg2data, out_pc, out_ctrl
    );

    modport master (
        output flush, in_valid, in_rs1, in_rs2, in_rd, in_pc, in_imm,
               in_srca_sel, in_srcb_sel, in_ctrl,
               wb_en, wb_addr, wb_data, out_ready,
        input  in_ready, out_valid, out_rd, out_alua, out_alub,
               out_reg2data, out_pc, out_ctrl
    );

endinterface

// File: rtl/rf_array.sv
// NREG x WIDTH architectural register array: one write port, two combinational
// read ports, x0 hardwired to zero. Define OCHIBA_RF_BYPASS_EN for write-through reads.
module rf_array
    import rf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    localparam int AW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wen,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr1,
    input  logic [AW-1:0]    raddr2,
    output logic [WIDTH-1:0] rdata1,
    output logic [WIDTH-1:0] rdata2
);

    logic [WIDTH-1:0] mem [NREG];
    logic             wr_ok;

    assign wr_ok = wen && (waddr != AW'(X0_IDX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_ok) begin
            mem[waddr] <= wdata;
        end
    end

    function automatic logic [WIDTH-1:0] read_port(input logic [AW-1:0] ra);
        if (ra == AW'(X0_IDX)) begin
            return '0;
        end
`ifdef OCHIBA_RF_BYPASS_EN
        if (wr_ok && (waddr == ra)) begin
            return wdata;
        end
`endif
        return mem[ra];
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: rtl/rf_read_stage.sv
// RV32I register-file read stage: reads operands, selects ALU inputs and holds them
// in a one-entry valid/ready pipeline register with flush. Optional macro: OCHIBA_RF_BYPASS_EN.
module rf_read_stage
    import rf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int NREG  = 32,
    parameter int CTRLW = CTRLW_DEF
) (
    input logic            clk,
    input logic            RFREGclear,
    rf_read_stage_if.slave bus
);

    localparam int AW = $clog2(NREG);

    logic [WIDTH-1:0] rs1_val;
    logic [WIDTH-1:0] rs2_val;
    logic [WIDTH-1:0] alua_d;
    logic [WIDTH-1:0] alub_d;
    logic             load;

    rf_array #(
        .WIDTH (WIDTH),
        .NREG  (NREG)
    ) u_array (
        .clk    (clk),
        .rst    (RFREGclear),
        .wen    (bus.wb_en),
        .waddr  (bus.wb_addr),
        .wdata  (bus.wb_data),
        .raddr1 (bus.in_rs1),
        .raddr2 (bus.in_rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    always_comb begin
        alua_d = '0;
        case (bus.in_srca_sel)
            SRCA_RS1: alua_d = rs1_val;
            SRCA_PC:  alua_d = bus.in_pc;
            default:  alua_d = '0;
        endcase
    end

    always_comb begin
        alub_d = '0;
        case (bus.in_srcb_sel)
            SRCB_RS2: alub_d = rs2_val;
            SRCB_IMM: alub_d = bus.in_imm;
            SRCB_ONE: alub_d = WIDTH'(1);
            default:  alub_d = '0;
        endcase
    end

    assign bus.in_ready = ~bus.out_valid | bus.out_ready;
    assign load         = bus.in_valid & bus.in_ready;

    // Flush wins over a simultaneous load; idle-but-ready cycles drop valid and keep data
    always_ff @(posedge clk or posedge RFREGclear) begin
        if (RFREGclear) begin
            bus.out_valid    <= 1'b0;
            bus.out_rd       <= '0;
            bus.out_alua     <= '0;
            bus.out_alub     <= '0;
            bus.out_reg2data <= '0;
            bus.out_pc       <= '0;
            bus.out_ctrl     <= '0;
        end else if (bus.flush) begin
            bus.out_valid <= 1'b0;
            bus.out_ctrl  <= '0;
        end else if (load) begin
            bus.out_valid    <= 1'b1;
            bus.out_rd       <= bus.in_rd;
            bus.out_alua     <= alua_d;
            bus.out_alub     <= alub_d;
            bus.out_reg2data <= rs2_val;
            bus.out_pc       <= bus.in_pc;
            bus.out_ctrl     <= bus.in_ctrl;
        end else if (bus.in_ready) begin
            bus.out_valid <= 1'b0;
        end
    end

endmodule
